alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute/writeback stage around the 32-bit combinational alu. Accepts decoded ops, reads two
//  operands from an internal 32x32 register file, drives the alu, then registers the result and
//  flags and writes the result back. It is a 2-stage pipeline (EX, WB) with a valid/ready
//  handshake on both sides and EX->operand bypass. It sits directly upstream of the alu.
// PARAMETERS
//  NREG   32  register count; r0 is hardwired to zero
//  W      32  datapath width; must match the alu
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  rst_n        in   1   synchronous, active-low reset
//  in_valid     in   1   op on in_* is presented
//  in_ready     out  1   stage accepts an op this cycle
//  in_op        in   3   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all others are illegal
//  in_rd        in   5   destination register
//  in_rs        in   5   A-operand register
//  in_rt        in   5   B-operand register (ignored when in_use_imm=1)
//  in_use_imm   in   1   1: B operand = in_imm
//  in_imm       in   W   immediate B operand
//  alu_a        out  W   to alu a
//  alu_b        out  W   to alu b
//  alu_op       out  3   to alu op (SLT drives 110)
//  alu_result   in   W   from alu
//  alu_cout, alu_zero, alu_set, alu_overflow  in 1 each  from alu
//  wb_valid     out  1   wb_rd/wb_data/wb_flags are valid
//  wb_ready     in   1   downstream consumes the WB entry
//  wb_rd        out  5   destination of the retired op
//  wb_data      out  W   retired result
//  wb_flags     out  4   {overflow,cout,set,zero} of the retired op
//  err          out  1   sticky; an illegal op was accepted
// BEHAVIOUR
//  - advance = !wb_valid | wb_ready; in_ready = advance. Accept = in_valid & in_ready.
//  - EX regs: ex_valid, ex_op, ex_rd, ex_a, ex_b. On accept, they load the operands. Otherwise,
//    when advance=1, ex_valid clears. When advance=0, they hold.
//  - Operand read is combinational in the accept cycle. rs/rt=0 reads 0.
//  - Bypass: if ex_valid & legal(ex_op) & ex_rd!=0 & ex_rd==rs (or rt), use alu_result
//    (SLT: {31'b0,alu_set}) in place of the regfile value.
//  - alu_a=ex_a, alu_b=ex_b. alu_op=ex_op, except SLT drives 110. These outputs are driven
//    from regs only.
//  - WB: when advance=1 and ex_valid=1 with a legal op:
//      wb_valid<=1, wb_rd<=ex_rd, wb_data<=result (SLT: {31'b0,alu_set}), wb_flags<=alu flags.
//      The regfile is written at the same edge, except when rd=0.
//  - When advance=1 and there is no legal EX op, wb_valid<=0.
//  - Illegal ex_op: the op is dropped at advance (no wb, no regfile write) and err<=1.
//  - Latency: accept at edge k -> wb_valid=1 after edge k+1 if wb_ready was held high.
//    Throughput is 1 op/cycle.
//  - Back-to-back dependent ops are bypassed. An op accepted at edge k+2 reads the written
//    regfile.
//  - Backpressure: wb_valid & !wb_ready holds WB and EX and forces in_ready=0. No op is lost,
//    duplicated, or reordered, and the regfile is written once per op.
//  - Reset (rst_n=0 at an edge), also mid-operation:
//      ex_valid=0, wb_valid=0, wb_rd=0, wb_data=0, wb_flags=0, err=0.
//      All regs are cleared to 0. In-flight ops are discarded with no write.
//    in_ready is combinational and reads 1 once reset is applied.
//  - Arithmetic wraps modulo 2^W. Flags are passed through from the alu unmodified.
// TESTING
//  1. Hold rst_n=0 for 2 edges -> wb_valid=0, in_ready=1, err=0, wb_flags=0.
//  2. Dependent ADD pair with wb_ready=1:
//       ADD rd=1 rs=0 imm=7 -> wb_data=7, wb_rd=1 one edge after accept.
//       Next cycle: ADD rd=2 rs=1 imm=3 -> wb_data=10 (bypass).
//  3. SUB rd=3 rs=1 rt=1 -> wb_data=0, wb_flags[0]=1.
//     SLT rd=4 rs=1 imm=10 -> wb_data=1.
//     SLT rd=5 rs=2 imm=3 -> wb_data=0.
//  4. Backpressure: issue ADD r6=r0+1 and ADD r7=r6+1, with wb_ready=0 for 3 cycles.
//       in_ready=0, wb_data=1 held.
//       After wb_ready=1: wb_data=1, then 2, in order with no duplicates.
//  5. ADD rd=0 imm=9 -> wb_valid=1 with wb_data=9, but a later ADD rd=8 rs=0 imm=0 gives 0.
//     in_op=011 -> no wb_valid, err=1 and stays 1 until reset.
//  6. Reset mid-flight: assert rst_n=0 while EX and WB are full.
//       wb_valid=0 next edge, target regs read 0 afterwards, no stray writeback.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage wrapped around an external
// combinational 32-bit alu.
//
// Decoded ops enter through the in_* handshake. Operands come from an internal
// register file, or are bypassed from the op currently in EX. The EX registers
// drive the alu. On advance, the alu result and flags move into the WB
// registers and are written back to the register file.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   op handshake; in_op, in_rd, in_rs, in_rt, in_use_imm, in_imm
//   alu_a/alu_b/alu_op  operands and opcode to the alu (register outputs)
//   alu_result, alu_cout, alu_zero, alu_set, alu_overflow   from the alu
//   wb_valid/wb_ready   retire handshake; wb_rd, wb_data, wb_flags {ov,cout,set,zero}
//   err                 sticky; set once an illegal op has been accepted
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on stage state and wb_ready, never on
// in_valid. wb_valid stays high, with stable payload, until wb_ready is seen.
module alu_exec_stage #(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_rs,
  input  logic [4:0]   in_rt,
  input  logic         in_use_imm,
  input  logic [W-1:0] in_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout,
  input  logic         alu_zero,
  input  logic         alu_set,
  input  logic         alu_overflow,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [4:0]   wb_rd,
  output logic [W-1:0] wb_data,
  output logic [3:0]   wb_flags,
  output logic         err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  logic [W-1:0] rf [NREG];

  logic         ex_valid;
  logic [2:0]   ex_op;
  logic [4:0]   ex_rd;
  logic [W-1:0] ex_a;
  logic [W-1:0] ex_b;

  logic         advance;
  logic         accept;
  logic         ex_legal;
  logic         ex_fwd;
  logic [W-1:0] ex_res;
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;

  always_comb begin
    advance  = !wb_valid || wb_ready;
    in_ready = advance;
    accept   = in_valid && advance;
    ex_legal = is_legal(ex_op);
    // SLT runs on the alu as a subtract; the result is the set flag alone.
    ex_res   = (ex_op == OP_SLT) ? {{(W-1){1'b0}}, alu_set} : alu_result;
    // The EX op can forward only when it will actually write a register.
    // Any accept happens on an advance edge, so the EX op reaches the
    // register file on that same edge and nothing older can be stale.
    ex_fwd   = ex_valid && ex_legal && (ex_rd != 5'd0);

    rd_a = '0;
    if (in_rs != 5'd0) begin
      rd_a = (ex_fwd && ex_rd == in_rs) ? ex_res : rf[in_rs];
    end

    rd_b = '0;
    if (in_use_imm) begin
      rd_b = in_imm;
    end else if (in_rt != 5'd0) begin
      rd_b = (ex_fwd && ex_rd == in_rt) ? ex_res : rf[in_rt];
    end

    alu_a  = ex_a;
    alu_b  = ex_b;
    alu_op = (ex_op == OP_SLT) ? OP_SUB : ex_op;
  end

  // Pipeline registers. Nothing moves unless advance is high, so a stalled
  // WB entry holds EX in place as well.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_flags <= '0;
      err      <= 1'b0;
    end else if (advance) begin
      if (ex_valid && ex_legal) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        wb_data  <= ex_res;
        wb_flags <= {alu_overflow, alu_cout, alu_set, alu_zero};
      end else begin
        wb_valid <= 1'b0;
      end
      // An illegal op is dropped here and leaves only the sticky flag behind.
      if (ex_valid && !ex_legal) begin
        err <= 1'b1;
      end
      ex_valid <= accept;
      if (accept) begin
        ex_op <= in_op;
        ex_rd <= in_rd;
        ex_a  <= rd_a;
        ex_b  <= rd_b;
      end
    end
  end

  // Register file. It is written exactly once per legal op, on the edge
  // where that op leaves EX. r0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (advance && ex_valid && ex_legal && ex_rd != 5'd0) begin
      rf[ex_rd] <= ex_res;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [4:0]   in_rd = '0;
  logic [4:0]   in_rs = '0;
  logic [4:0]   in_rt = '0;
  logic         in_use_imm = 1'b0;
  logic [W-1:0] in_imm = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_cout, alu_zero, alu_set, alu_overflow;
  logic         wb_valid;
  logic         wb_ready = 1'b1;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic [3:0]   wb_flags;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_bp  = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_exec_stage #(.NREG(32), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_set(alu_set),
    .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_flags(wb_flags), .err(err)
  );

  // ---------------- external alu (combinational) ----------------
  always_comb begin
    logic [32:0] s;
    s            = '0;
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    alu_set      = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = s[31:0];
        alu_cout     = s[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      3'b110: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = s[31:0];
        alu_cout     = s[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
        alu_set      = s[31] ^ alu_overflow;
      end
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // ---------------- reference model ----------------
  logic [W-1:0] mrf [32];
  logic [40:0]  exp_q [$];   // {rd[4:0], flags[3:0], data[31:0]}
  logic         exp_err = 1'b0;

  function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic legal,
                                   output logic [31:0] res, output logic [3:0] fl);
    longint sa, sb, r;
    logic ov, cy, st;
    logic [31:0] raw;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0; cy = 1'b0; st = 1'b0; legal = 1'b1; raw = '0;
    case (op)
      3'd0: raw = a & b;
      3'd1: raw = a | b;
      3'd2: begin
        raw = a + b;
        cy  = (longint'(a) + longint'(b)) > 64'sd4294967295;
        r   = sa + sb;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd6, 3'd7: begin
        raw = a - b;
        cy  = (a >= b);
        r   = sa - sb;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        st  = (sa < sb);
      end
      default: legal = 1'b0;
    endcase
    res = (op == 3'd7) ? {31'd0, st} : raw;
    fl  = {ov, cy, st, (raw == 32'd0)};
  endfunction

  task automatic model_accept();
    logic [31:0] a, b, res;
    logic [3:0]  fl;
    logic        legal;
    a = (in_rs == 0) ? 32'd0 : mrf[in_rs];
    b = in_use_imm ? in_imm : ((in_rt == 0) ? 32'd0 : mrf[in_rt]);
    ref_exec(in_op, a, b, legal, res, fl);
    if (legal) begin
      exp_q.push_back({in_rd, fl, res});
      if (in_rd != 0) mrf[in_rd] = res;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor (negedge sampling) ----------------
  always @(negedge clk) begin
    logic [40:0] e;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      exp_err = 1'b0;
    end else begin
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", {27'd0, wb_rd}, {27'd0, e[40:36]});
          check("wb_flags", {28'd0, wb_flags}, {28'd0, e[35:32]});
          check("wb_data", wb_data, e[31:0]);
        end
      end
      if (in_valid && in_ready) model_accept();
    end
  end

  // Random backpressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_bp) wb_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ui, input logic [31:0] imm);
    bit done;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_use_imm = ui; in_imm = imm;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_and_see(input string tag, input logic [2:0] op, input logic [4:0] rd,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                               input logic [31:0] imm, input logic [31:0] exp);
    send(op, rd, rs, rt, ui, imm);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
    check(tag, wb_data, exp);
  endtask

  task automatic drain();
    bit done;
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    wb_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !wb_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  legal_ops [5];
    logic [31:0] edge_vals [6];
    logic [2:0]  op;
    logic [31:0] imm;
    legal_ops = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    edge_vals = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0001};

    // 1. reset
    do_reset(2);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wb_flags", {28'd0, wb_flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2. dependent ADD pair, one-edge latency and bypass
    send(3'b010, 5'd1, 5'd0, 5'd0, 1'b1, 32'd7);
    send(3'b010, 5'd2, 5'd1, 5'd0, 1'b1, 32'd3);
    check("lat_valid", {31'd0, wb_valid}, 32'd1);
    check("lat_rd", {27'd0, wb_rd}, 32'd1);
    check("lat_data", wb_data, 32'd7);
    @(posedge clk);
    #1;
    check("byp_rd", {27'd0, wb_rd}, 32'd2);
    check("byp_data", wb_data, 32'd10);
    drain();

    // 3. SUB zero flag and SLT
    issue_and_see("sub_data", 3'b110, 5'd3, 5'd1, 5'd1, 1'b0, 32'd0, 32'd0);
    check("sub_zero", {31'd0, wb_flags[0]}, 32'd1);
    issue_and_see("slt_true", 3'b111, 5'd4, 5'd1, 5'd0, 1'b1, 32'd10, 32'd1);
    issue_and_see("slt_false", 3'b111, 5'd5, 5'd2, 5'd0, 1'b1, 32'd3, 32'd0);
    drain();

    // 4. backpressure
    wb_ready = 1'b0;
    send(3'b010, 5'd6, 5'd0, 5'd0, 1'b1, 32'd1);
    send(3'b010, 5'd7, 5'd6, 5'd0, 1'b1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold", wb_data, 32'd1);
    end
    drain();

    // 5. rd=0 writeback, r0 still reads zero (bypass excluded), illegal op
    send(3'b010, 5'd0, 5'd0, 5'd0, 1'b1, 32'd9);
    send(3'b010, 5'd8, 5'd0, 5'd0, 1'b1, 32'd0);
    check("r0_wb_data", wb_data, 32'd9);
    @(posedge clk);
    #1;
    check("r0_reads_zero", wb_data, 32'd0);
    drain();
    send(3'b011, 5'd9, 5'd1, 5'd1, 1'b0, 32'd0);
    drain();
    check("err_set", {31'd0, err}, {31'd0, exp_err});
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", {31'd0, err}, 32'd1);

    // 6. reset with EX and WB both full
    wb_ready = 1'b0;
    send(3'b010, 5'd9, 5'd0, 5'd0, 1'b1, 32'd5);
    send(3'b010, 5'd10, 5'd0, 5'd0, 1'b1, 32'd6);
    do_reset(1);
    check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue_and_see("r9_cleared", 3'b010, 5'd11, 5'd9, 5'd0, 1'b1, 32'd0, 32'd0);
    issue_and_see("r1_cleared", 3'b001, 5'd12, 5'd1, 5'd10, 1'b0, 32'd0, 32'd0);
    drain();

    // 7. randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      op  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(3, 5))
                                         : legal_ops[$urandom_range(0, 4)];
      imm = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      send(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
    end
    drain();
    check("rand_err", {31'd0, err}, {31'd0, exp_err});
    check("rand_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
